// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data stages.
// Data wins ties unless fetch has waited STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    state_t state, stateNext;
    logic [3:0] starveCnt;
    logic grantDm, grantIf, idleGrant;
    assign grantDm   = dm_req & (~if_req | (starveCnt != STARVE_LIM));
    assign grantIf   = if_req & ~grantDm;
    assign idleGrant = (state == IDLE) & (grantDm | grantIf);
    always_comb begin
        stateNext = state;
        if (idleGrant)
            stateNext = BUSY;
        else if (state == BUSY && mem_ack)
            stateNext = RESP;
        else if (state == RESP)
            stateNext = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            starveCnt <= '0;
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state <= stateNext;
            if (idleGrant) begin
                owner     <= grantDm;
                mem_addr  <= grantDm ? dm_addr : if_addr;
                mem_we    <= grantDm & dm_we;
                mem_wdata <= grantDm ? dm_wdata : '0;
                starveCnt <= grantIf ? '0 : (if_req && starveCnt != STARVE_LIM) ? starveCnt + 4'd1 : starveCnt;
            end
            // stores leave the owner's read register untouched
            if (state == BUSY && mem_ack && !mem_we) begin
                if (owner)
                    dm_rdata <= mem_rdata;
                else
                    if_rdata <= mem_rdata;
            end
        end
    end
    assign mem_req  = state == BUSY;
    assign if_done  = (state == RESP) & ~owner;
    assign dm_done  = (state == RESP) & owner;
    assign stall_if = if_req & ~if_done;
    assign stall_dm = dm_req & ~dm_done;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port instruction/data memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RISC-V pipeline.
- Serializes requests, latches address and data, sequences the memory handshake, and returns read data with a one-cycle done pulse.
- Drives per-requester stall signals into the existing stall/flush logic.
- Data-side has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced (range 1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
if_req  input  1  fetch requests an instruction read; held high until if_done
if_addr  input  ADDR_W  fetch address (PC)
if_rdata  output  DATA_W  instruction; valid while if_done=1
if_done  output  1  one-cycle completion pulse to fetch
dm_req  input  1  memory stage requests access; held high until dm_done
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address (ALU result)
dm_wdata  input  DATA_W  store data
dm_rdata  output  DATA_W  load data; valid while dm_done=1
dm_done  output  1  one-cycle completion pulse to memory stage
mem_req  output  1  request to shared memory
mem_we  output  1  write enable to memory
mem_addr  output  ADDR_W  latched address
mem_wdata  output  DATA_W  latched write data
mem_ack  input  1  memory completes the current access this cycle
mem_rdata  input  DATA_W  read data; valid when mem_ack=1
stall_if  output  1  if_req & ~if_done (combinational)
stall_dm  output  1  dm_req & ~dm_done (combinational)
owner  output  1  current grant: 0 = fetch, 1 = data; meaningful in BUSY/RESP

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (rst=0, asynchronous):
  - state=IDLE, starve_cnt=0, owner=0.
  - mem_req, mem_we, if_done, dm_done = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Reset mid-BUSY drops mem_req immediately. The in-flight access is abandoned; a write may or may not have committed.
- IDLE, grant selection (requests sampled only in IDLE):
  - dm_req only -> grant data.
  - if_req only -> grant fetch.
  - Both -> grant data unless starve_cnt == STARVE_MAX, then grant fetch.
  - Neither -> remain IDLE.
- On grant: latch addr/we/wdata of the winner into mem_* registers, set owner, go to BUSY.
  - Fetch grant forces mem_we=0, mem_wdata=0.
- Starve counter:
  - Data grant while if_req=1: starve_cnt += 1, saturating at STARVE_MAX.
  - Any fetch grant: starve_cnt = 0.
  - Data grant while if_req=0: starve_cnt unchanged.
- BUSY:
  - mem_req=1, mem_* held stable.
  - Wait any number of cycles for mem_ack.
  - On mem_ack: capture mem_rdata into the owner's rdata register (stores capture nothing; dm_rdata keeps its previous value), mem_req=0 next cycle, go to RESP.
- RESP:
  - Owner's done=1 for exactly one cycle, then IDLE.
  - Requests are ignored in RESP. A requester holding req high across done issues a new transaction, sampled in the following IDLE.
- Latency: req seen in IDLE at cycle N -> mem_req at N+1 -> with mem_ack at N+1, done at N+2. Minimum 3 cycles per access; back-to-back throughput is one access per 3 cycles.
- if_done and dm_done are never high together; mem_req is never high in IDLE or RESP.
- if_addr/dm_addr changes after grant have no effect on the current access.
- mem_ack outside BUSY is ignored.

Test Plan:
- Reset: rst=0 during BUSY with mem_req=1 -> mem_req=0 immediately, all outputs 0, state IDLE; after rst=1, if_req=1 gets granted normally.
- Single fetch: if_req=1, if_addr=0x0000_0010, mem_ack in first BUSY cycle with mem_rdata=0x0051_0093 -> mem_addr=0x10, mem_we=0, if_done pulse 2 cycles after request with if_rdata=0x0051_0093; stall_if=1 until that cycle.
- Store with wait states: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, mem_ack delayed 3 cycles -> mem_req held 4 cycles with stable fields, dm_done one cycle after ack, dm_rdata unchanged.
- Simultaneous requests: if_req=dm_req=1 from IDLE -> data served first (owner=1), fetch served next; if_done follows dm_done by 3 cycles.
- Starvation: dm_req and if_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt returns to 0 after each F.
- Address change after grant: change if_addr to 0x20 during BUSY -> mem_addr stays 0x10 until RESP; the next transaction uses 0x20.
